down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Synchronous, loadable down-counter/timer. It is the count-down companion to the team's T-flip-flop ripple up-counter. It loads a start value, decrements once per prescaled tick while enabled, and pulses a terminal-count flag on reaching zero. It optionally auto-reloads to produce a periodic tick. It sits beside the ripple counter in the counter/timing library and drives event or timeout logic.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- PRESCALE, 1: number of enabled clk cycles per count tick; legal range 1..256; 1 means a tick on every enabled cycle.

- clk  input  1  rising-edge clock; all state is updated on it.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  load request, sampled on clk.
- load_value  input  WIDTH  start/reload value, captured when load=1.
- enable  input  1  count enable; 0 freezes q and the prescaler.
- auto_reload  input  1  1 = reload from the stored value at terminal count; 0 = stop at zero.
- q  output  WIDTH  current count, registered.
- busy  output  1  1 while in RUN state, registered.
- tc  output  1  terminal-count pulse, registered, one clk wide.

## Operation
- State machine has two states.
  - IDLE: q holds its value and busy=0.
  - RUN: busy=1.
- Internal registers:
  - reload_reg (WIDTH bits): holds the last loaded value.
  - presc_cnt: width ceil(log2(PRESCALE)), minimum 1 bit.
- A tick occurs when enable=1 and presc_cnt==PRESCALE-1.
  - On a tick, presc_cnt wraps to 0.
  - Otherwise, if enable=1, presc_cnt increments.
  - If enable=0, presc_cnt holds.
  - For PRESCALE=1, every enabled cycle is a tick.
- Priority per clk edge, highest first: reset, load, tick.
- load=1, in any state:
  - q<=load_value, reload_reg<=load_value, presc_cnt<=0, tc<=0.
  - If load_value!=0: go to RUN. If load_value==0: go to IDLE.
  - enable is ignored in the load cycle.
- RUN with a tick and q>1: q<=q-1; tc<=0.
- RUN with a tick and q==1 (terminal tick):
  - tc<=1.
  - If auto_reload=1 and reload_reg!=0: q<=reload_reg and stay in RUN.
  - Otherwise: q<=0 and go to IDLE.
- IDLE: ticks have no effect on q. presc_cnt still advances while enable=1; this is harmless because load clears it.
- tc defaults to 0 on every edge that is not a terminal tick.
- Arithmetic is unsigned. q never wraps below 0; decrement from 0 is impossible because q==0 implies IDLE.
- auto_reload is sampled only at the terminal tick. It may change mid-run.

## Timing
- Reset values (asynchronous, immediate on reset=0): q=0, busy=0, tc=0, presc_cnt=0, reload_reg=0, state=IDLE.
- Reset release: the first functional edge is the first rising clk edge with reset=1.
- Load latency: q and busy reflect load_value on the edge that samples load=1.
- Run length: from the load edge, N = load_value ticks until tc.
  - With enable held at 1, tc is high in clock cycle N*PRESCALE after the load edge. It is asserted on that edge and lasts exactly one cycle.
- Auto-reload period: the tc-to-tc spacing is reload_reg*PRESCALE enabled cycles, with no dead cycle. q shows the reload value on the same edge that raises tc.
- Load coinciding with the terminal tick: load wins; tc stays 0 and q=load_value.
- enable deasserted mid-prescale: presc_cnt freezes. On re-enable, counting resumes from the frozen phase with no lost or extra tick.
- Reset asserted mid-run: all outputs clear asynchronously, without waiting for clk. A pending tc is lost.
- busy falls on the same edge tc rises (non-reload case). busy stays 1 across reloads.

## Test plan
- Reset check: WIDTH=4, PRESCALE=1. Drive reset=0 mid-cycle -> q=0, busy=0, tc=0 immediately. Release reset and hold load=0 -> all outputs stay 0.
- One-shot run: WIDTH=4, PRESCALE=1. load=1 with load_value=5 for one cycle, enable=1, auto_reload=0.
  - q is 5,4,3,2,1,0 on consecutive edges.
  - tc=1 only in the edge where q becomes 0; busy=0 from that edge.
- Auto-reload with prescale: PRESCALE=3, load_value=2, auto_reload=1, enable=1.
  - tc pulses every 6 cycles.
  - q sequence: 2 (3 cycles), 1 (3 cycles), 2 (3 cycles)...
- Enable gap: PRESCALE=3, load_value=3. Drop enable for 4 cycles after the 2nd enabled cycle -> tc is delayed by exactly 4 cycles versus the ungated case (9 to 13).
- Collisions:
  - load_value=7 asserted on the terminal-tick edge -> tc=0, q=7, busy=1.
  - load_value=0 -> q=0, busy=0, tc never pulses.
- Reset mid-run: load_value=9, reset=0 after 4 ticks -> q=0, busy=0 asynchronously. After release, no tc occurs without a new load.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaler, terminal-count pulse and optional auto-reload.
// Count-down companion to the ripple up-counter in the counter/timing library.
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic             busy_q;
  logic             tc_q;
  logic             tick;

  // The prescaler keeps running in IDLE; a load always realigns its phase.
  assign tick    = enable && (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : (enable ? presc_q + PW'(1) : presc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q  <= load_value;
        reload_q <= load_value;
        presc_q  <= '0;
        if (load_value != '0) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        presc_q <= presc_d;
        if (state_q == RUN && tick) begin
          if (count_q > WIDTH'(1)) begin
            count_q <= count_q - WIDTH'(1);
          end else begin
            // RUN guarantees count_q != 0, so this is the terminal tick.
            tc_q <= 1'b1;
            if (auto_reload && reload_q != '0) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign q    = count_q;
  assign busy = busy_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: one PRESCALE=1 and one PRESCALE=3 instance share stimulus;
// expected q/busy/tc triples are queued as stimulus is driven and popped after each edge.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [3:0] q1, q3;
  logic       busy1, busy3, tc1, tc3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload), .q(q1), .busy(busy1), .tc(tc1)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload), .q(q3), .busy(busy3), .tc(tc3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; load_value = 4'd0; enable = 1'b0; auto_reload = 1'b0;
    step();
    checks++;
    if ({q1, busy1, tc1, q3, busy3, tc3} !== 12'b0) begin
      errors++;
      $display("FAIL reset_initial q1=%0d b1=%b t1=%b q3=%0d b3=%b t3=%b want all 0", q1, busy1, tc1, q3, busy3, tc3);
    end
    reset = 1'b1;
    load = 1'b1; load_value = 4'd5; enable = 1'b1;
    step();
    load = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({q1, busy1, tc1, q3, busy3, tc3} !== 12'b0) begin
      errors++;
      $display("FAIL reset_async q1=%0d b1=%b t1=%b q3=%0d b3=%b want 0", q1, busy1, tc1, q3, busy3);
    end
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back('{q: 4'd0, busy: 1'b0, tc: 1'b0});
    for (int k = 0; k < 3; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e || {q3, busy3, tc3} !== e) begin
        errors++;
        $display("FAIL reset_release c%0d q1/b/t=%0d/%b/%b q3/b/t=%0d/%b/%b want 0/0/0", k, q1, busy1, tc1, q3, busy3, tc3);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] seq [8] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    load = 1'b1; load_value = 4'd5; enable = 1'b1; auto_reload = 1'b0;
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{q: seq[k], busy: (k < 5), tc: (k == 5)});
    for (int k = 0; k < 8; k++) begin
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e) begin
        errors++;
        $display("FAIL one_shot c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q1, busy1, tc1, e.q, e.busy, e.tc);
      end
    end
  endtask

  task automatic test_auto_prescale();
    load = 1'b1; load_value = 4'd2; enable = 1'b1; auto_reload = 1'b1;
    for (int k = 0; k < 14; k++)
      exp_q.push_back('{q: ((k % 6) < 3) ? 4'd2 : 4'd1, busy: 1'b1, tc: (k > 0 && (k % 6) == 0)});
    for (int k = 0; k < 14; k++) begin
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({q3, busy3, tc3} !== e) begin
        errors++;
        $display("FAIL auto_prescale c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q3, busy3, tc3, e.q, e.busy, e.tc);
      end
    end
  endtask

  task automatic test_enable_gap();
    int en_cnt;
    int tc_at;
    en_cnt = 0;
    tc_at = -1;
    load = 1'b1; load_value = 4'd3; enable = 1'b1; auto_reload = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k >= 1 && (k <= 2 || k >= 7)) en_cnt++;
      exp_q.push_back('{q: (en_cnt >= 9) ? 4'd0 : 4'(3 - en_cnt / 3), busy: (en_cnt < 9), tc: (k == 13)});
    end
    for (int k = 0; k < 16; k++) begin
      if (k >= 1) enable = (k <= 2 || k >= 7);
      step();
      load = 1'b0;
      if (tc3 === 1'b1 && tc_at < 0) tc_at = k;
      e = exp_q.pop_front();
      checks++;
      if ({q3, busy3, tc3} !== e) begin
        errors++;
        $display("FAIL enable_gap c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q3, busy3, tc3, e.q, e.busy, e.tc);
      end
    end
    checks++;
    if (tc_at != 13) begin
      errors++;
      $display("FAIL enable_gap_tc_cycle got %0d want 13", tc_at);
    end
    enable = 1'b1;
  endtask

  task automatic test_load_collision();
    logic [3:0] seq [5] = '{4'd3, 4'd2, 4'd1, 4'd7, 4'd6};
    load = 1'b1; load_value = 4'd3; enable = 1'b1; auto_reload = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back('{q: seq[k], busy: 1'b1, tc: 1'b0});
    for (int k = 0; k < 5; k++) begin
      load = (k == 0 || k == 3);
      load_value = (k == 3) ? 4'd7 : 4'd3;
      step();
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e) begin
        errors++;
        $display("FAIL load_collision c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q1, busy1, tc1, e.q, e.busy, e.tc);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_zero();
    load = 1'b1; load_value = 4'd0; enable = 1'b1; auto_reload = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back('{q: 4'd0, busy: 1'b0, tc: 1'b0});
    for (int k = 0; k < 6; k++) begin
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e || {q3, busy3, tc3} !== e) begin
        errors++;
        $display("FAIL load_zero c%0d q1/b/t=%0d/%b/%b q3/b/t=%0d/%b/%b want 0/0/0", k, q1, busy1, tc1, q3, busy3, tc3);
      end
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_value = 4'd1; enable = 1'b1; auto_reload = 1'b1;
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{q: (k < 6) ? 4'd1 : 4'd0, busy: (k < 6), tc: (k >= 1 && k <= 6)});
    for (int k = 0; k < 8; k++) begin
      if (k == 6) auto_reload = 1'b0;
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e) begin
        errors++;
        $display("FAIL back_to_back c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q1, busy1, tc1, e.q, e.busy, e.tc);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int tc_seen;
    tc_seen = 0;
    load = 1'b1; load_value = 4'd9; enable = 1'b1; auto_reload = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back('{q: 4'(9 - k), busy: 1'b1, tc: 1'b0});
    for (int k = 0; k < 5; k++) begin
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({q1, busy1, tc1} !== e) begin
        errors++;
        $display("FAIL reset_mid_run_pre c%0d q/busy/tc=%0d/%b/%b want %0d/%b/%b", k, q1, busy1, tc1, e.q, e.busy, e.tc);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({q1, busy1, tc1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_run_async q/busy/tc=%0d/%b/%b want 0/0/0", q1, busy1, tc1);
    end
    step();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tc1 !== 1'b0 || busy1 !== 1'b0 || q1 !== 4'd0) tc_seen++;
    end
    checks++;
    if (tc_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_run_post nonzero cycles=%0d want 0", tc_seen);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_prescale();
    test_enable_gap();
    test_load_collision();
    test_load_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
